// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style interrupt scheduler:
// FSM encoding, OCW2 command codes and the level-mask helper.
package pic_pkg;

    localparam int          PIC_NUM_IR           = 8;
    localparam logic [2:0]  DEFAULT_RESET_LOWEST = 3'd7;
    localparam logic [2:0]  SPURIOUS_IR          = 3'd7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INT_PEND = 2'd1,
        ACK1     = 2'd2,
        ACK2     = 2'd3
    } pic_state_e;

    // OCW2 {R,SL,EOI}
    localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

    function automatic logic [7:0] level_mask(input logic [2:0] lvl);
        return 8'h01 << lvl;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational priority resolver: rotates request and in-service vectors so the
// highest-priority level sits at bit 0, finds the first set bit, then un-rotates.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] req,
    input  logic [7:0] isr,
    input  logic [2:0] lowest,
    output logic       valid,
    output logic [2:0] level
);

    logic [2:0] base_s;
    logic [7:0] req_rot_s;
    logic [7:0] isr_rot_s;
    logic [3:0] req_rank_s;
    logic [3:0] isr_rank_s;

    assign base_s = lowest + 3'd1;

    // rotate both vectors and find the best rank of each (8 = none)
    always_comb begin
        logic [2:0] idx_v;
        idx_v      = 3'd0;
        req_rot_s  = 8'h00;
        isr_rot_s  = 8'h00;
        req_rank_s = 4'd8;
        isr_rank_s = 4'd8;
        for (int i = 0; i < PIC_NUM_IR; i++) begin
            idx_v        = 3'(i) + base_s;
            req_rot_s[i] = req[idx_v];
            isr_rot_s[i] = isr[idx_v];
        end
        for (int i = PIC_NUM_IR - 1; i >= 0; i--) begin
            req_rank_s = req_rot_s[i] ? 4'(i) : req_rank_s;
            isr_rank_s = isr_rot_s[i] ? 4'(i) : isr_rank_s;
        end
    end

    // a request only wins when strictly above every in-service level
    assign valid = (req_rank_s < isr_rank_s);
    assign level = req_rank_s[2:0] + base_s;

endmodule

// File: rtl/pic_priority_scheduler.sv
// 8259 interrupt scheduler: IRR/ISR bookkeeping, nested/rotating priority,
// the two-pulse INTA_ sequence and OCW2 EOI/rotation commands.
module pic_priority_scheduler
    import pic_pkg::*;
#(
    parameter int         NUM_IR       = PIC_NUM_IR,
    parameter logic [2:0] RESET_LOWEST = DEFAULT_RESET_LOWEST
) (
    input  logic              CLK,
    input  logic              RST_,
    input  logic [NUM_IR-1:0] IR_IN,
    input  logic              LTIM,
    input  logic [NUM_IR-1:0] IMR,
    input  logic              AEOI,
    input  logic              INTA_,
    input  logic              OCW2_WR,
    input  logic [2:0]        OCW2_CMD,
    input  logic [2:0]        OCW2_L,
    output logic              INT,
    output logic [2:0]        IR_NUM,
    output logic [1:0]        INTA_COUNT,
    output logic [NUM_IR-1:0] IRR,
    output logic [NUM_IR-1:0] ISR
);

    pic_state_e        state_r, state_s;
    logic              int_r, int_s;
    logic [2:0]        ir_num_r, ir_num_s;
    logic [1:0]        inta_cnt_r, inta_cnt_s;
    logic [NUM_IR-1:0] irr_r, irr_s;
    logic [NUM_IR-1:0] isr_r, isr_s;
    logic [2:0]        lowest_r, lowest_s;
    logic              rot_aeoi_r, rot_aeoi_s;
    logic              spurious_r, spurious_s;
    logic [NUM_IR-1:0] ir_prev_r;
    logic              inta_prev_r;

    logic              inta_fall_s, inta_rise_s;
    logic [NUM_IR-1:0] cand_req_s;
    logic              cand_valid_s, isr_valid_s;
    logic [2:0]        cand_level_s, isr_level_s;
    logic [NUM_IR-1:0] isr_set_s, irr_clr_s, aeoi_clr_s, ocw_clr_s;
    logic              aeoi_rot_s;

    assign inta_fall_s = inta_prev_r & ~INTA_;
    assign inta_rise_s = ~inta_prev_r & INTA_;
    assign cand_req_s  = irr_r & ~IMR;

    pic_priority_resolver u_cand (
        .req    (cand_req_s),
        .isr    (isr_r),
        .lowest (lowest_r),
        .valid  (cand_valid_s),
        .level  (cand_level_s)
    );

    // with no blocking vector this yields the highest-priority in-service level
    pic_priority_resolver u_isr_top (
        .req    (isr_r),
        .isr    (8'h00),
        .lowest (lowest_r),
        .valid  (isr_valid_s),
        .level  (isr_level_s)
    );

    // acknowledge sequencer: next state, INT, IR_NUM, pulse count and ISR/IRR effects
    always_comb begin
        state_s    = state_r;
        int_s      = int_r;
        ir_num_s   = ir_num_r;
        inta_cnt_s = inta_cnt_r;
        spurious_s = spurious_r;
        isr_set_s  = 8'h00;
        irr_clr_s  = 8'h00;
        aeoi_clr_s = 8'h00;
        aeoi_rot_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cand_valid_s) begin
                    state_s = INT_PEND;
                    int_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            INT_PEND: begin
                if (inta_fall_s) begin
                    state_s    = ACK1;
                    inta_cnt_s = 2'd1;
                    if (cand_valid_s) begin
                        ir_num_s   = cand_level_s;
                        spurious_s = 1'b0;
                        isr_set_s  = level_mask(cand_level_s);
                        irr_clr_s  = level_mask(cand_level_s);
                    end else begin
                        ir_num_s   = SPURIOUS_IR;
                        spurious_s = 1'b1;
                    end
                end else if (!cand_valid_s) begin
                    state_s = IDLE;
                    int_s   = 1'b0;
                end else begin
                    state_s = INT_PEND;
                end
            end
            ACK1: begin
                if (inta_fall_s) begin
                    state_s    = ACK2;
                    inta_cnt_s = 2'd2;
                end else begin
                    state_s = ACK1;
                end
            end
            ACK2: begin
                if (inta_rise_s) begin
                    state_s    = IDLE;
                    int_s      = 1'b0;
                    inta_cnt_s = 2'd0;
                    if (AEOI && !spurious_r) begin
                        aeoi_clr_s = level_mask(ir_num_r);
                        aeoi_rot_s = rot_aeoi_r;
                    end else begin
                        aeoi_clr_s = 8'h00;
                    end
                end else begin
                    state_s = ACK2;
                end
            end
            default: begin
                state_s    = IDLE;
                int_s      = 1'b0;
                inta_cnt_s = 2'd0;
            end
        endcase
    end

    // OCW2 decode; a command's priority change overrides an AEOI rotation in the same cycle
    always_comb begin
        ocw_clr_s  = 8'h00;
        lowest_s   = aeoi_rot_s ? ir_num_r : lowest_r;
        rot_aeoi_s = rot_aeoi_r;
        if (OCW2_WR) begin
            case (OCW2_CMD)
                OCW2_NS_EOI:       ocw_clr_s = isr_valid_s ? level_mask(isr_level_s) : 8'h00;
                OCW2_SP_EOI:       ocw_clr_s = level_mask(OCW2_L);
                OCW2_ROT_NS_EOI: begin
                    if (isr_valid_s) begin
                        ocw_clr_s = level_mask(isr_level_s);
                        lowest_s  = isr_level_s;
                    end else begin
                        ocw_clr_s = 8'h00;
                    end
                end
                OCW2_ROT_SP_EOI: begin
                    ocw_clr_s = level_mask(OCW2_L);
                    lowest_s  = OCW2_L;
                end
                OCW2_SET_PRIO:     lowest_s   = OCW2_L;
                OCW2_SET_ROT_AEOI: rot_aeoi_s = 1'b1;
                OCW2_CLR_ROT_AEOI: rot_aeoi_s = 1'b0;
                OCW2_NOP:          ocw_clr_s  = 8'h00;
                default:           ocw_clr_s  = 8'h00;
            endcase
        end else begin
            ocw_clr_s = 8'h00;
        end
    end

    // set wins over clear for both registers
    assign isr_s = (isr_r & ~(ocw_clr_s | aeoi_clr_s)) | isr_set_s;
    assign irr_s = LTIM ? IR_IN : ((irr_r & ~irr_clr_s) | (IR_IN & ~ir_prev_r));

    // state and register update
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state_r     <= IDLE;
            int_r       <= 1'b0;
            ir_num_r    <= 3'd0;
            inta_cnt_r  <= 2'd0;
            irr_r       <= 8'h00;
            isr_r       <= 8'h00;
            lowest_r    <= RESET_LOWEST;
            rot_aeoi_r  <= 1'b0;
            spurious_r  <= 1'b0;
            ir_prev_r   <= 8'h00;
            inta_prev_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            int_r       <= int_s;
            ir_num_r    <= ir_num_s;
            inta_cnt_r  <= inta_cnt_s;
            irr_r       <= irr_s;
            isr_r       <= isr_s;
            lowest_r    <= lowest_s;
            rot_aeoi_r  <= rot_aeoi_s;
            spurious_r  <= spurious_s;
            ir_prev_r   <= IR_IN;
            inta_prev_r <= INTA_;
        end
    end

    assign INT        = int_r;
    assign IR_NUM     = ir_num_r;
    assign INTA_COUNT = inta_cnt_r;
    assign IRR        = irr_r;
    assign ISR        = isr_r;

endmodule

// File: tb/tb_pic_priority_scheduler.sv
// Self-checking bench for pic_priority_scheduler: vector table, directed corner
// sequences and randomized traffic against a behavioural priority model.
module tb_pic_priority_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ir_in = 8'h00;
    logic       ltim = 1'b0;
    logic [7:0] imr = 8'h00;
    logic       aeoi = 1'b0;
    logic       inta_n = 1'b1;
    logic       ocw2_wr = 1'b0;
    logic [2:0] ocw2_cmd = 3'd0;
    logic [2:0] ocw2_l = 3'd0;
    logic       int_o;
    logic [2:0] ir_num;
    logic [1:0] inta_count;
    logic [7:0] irr;
    logic [7:0] isr;

    int total = 0;
    int bad = 0;

    pic_priority_scheduler dut (
        .CLK        (clk),
        .RST_       (rst_n),
        .IR_IN      (ir_in),
        .LTIM       (ltim),
        .IMR        (imr),
        .AEOI       (aeoi),
        .INTA_      (inta_n),
        .OCW2_WR    (ocw2_wr),
        .OCW2_CMD   (ocw2_cmd),
        .OCW2_L     (ocw2_l),
        .INT        (int_o),
        .IR_NUM     (ir_num),
        .INTA_COUNT (inta_count),
        .IRR        (irr),
        .ISR        (isr)
    );

    always #5 clk = ~clk;

    // behavioural model: acknowledge phase 0 idle, 1 INT raised, 2 one pulse, 3 two pulses
    logic [7:0] m_irr, m_isr, m_prev_ir;
    int         m_low, m_phase, m_cnt, m_irnum;
    bit         m_rot, m_int, m_spur, m_prev_inta;

    // walk from highest to lowest priority; an in-service level met first blocks everything below
    function automatic int pick(input logic [7:0] req, input logic [7:0] blk, input int low);
        for (int k = 1; k <= 8; k++) begin
            int lv;
            lv = (low + k) % 8;
            if (blk[lv]) return -1;
            if (req[lv]) return lv;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_irr = 8'h00; m_isr = 8'h00; m_prev_ir = 8'h00;
        m_low = 7; m_phase = 0; m_cnt = 0; m_irnum = 0;
        m_rot = 1'b0; m_int = 1'b0; m_spur = 1'b0; m_prev_inta = 1'b1;
    endtask

    task automatic model_step();
        int cand, h, new_low;
        logic [7:0] set_m, clr_m, irr_clr;
        bit fall, rise;
        cand = pick(m_irr & ~imr, m_isr, m_low);
        fall = m_prev_inta && !inta_n;
        rise = !m_prev_inta && inta_n;
        set_m = 8'h00; clr_m = 8'h00; irr_clr = 8'h00; new_low = m_low;
        if (m_phase == 0) begin
            if (cand >= 0) begin m_phase = 1; m_int = 1'b1; end
        end else if (m_phase == 1) begin
            if (fall) begin
                m_phase = 2; m_cnt = 1;
                if (cand >= 0) begin
                    m_irnum = cand; m_spur = 1'b0;
                    set_m[cand] = 1'b1; irr_clr[cand] = 1'b1;
                end else begin
                    m_irnum = 7; m_spur = 1'b1;
                end
            end else if (cand < 0) begin
                m_phase = 0; m_int = 1'b0;
            end
        end else if (m_phase == 2) begin
            if (fall) begin m_phase = 3; m_cnt = 2; end
        end else begin
            if (rise) begin
                m_phase = 0; m_int = 1'b0; m_cnt = 0;
                if (aeoi && !m_spur) begin
                    clr_m[m_irnum] = 1'b1;
                    if (m_rot) new_low = m_irnum;
                end
            end
        end
        if (ocw2_wr) begin
            h = pick(m_isr, 8'h00, m_low);
            case (ocw2_cmd)
                3'b001: if (h >= 0) clr_m[h] = 1'b1;
                3'b101: if (h >= 0) begin clr_m[h] = 1'b1; new_low = h; end
                3'b011: clr_m[ocw2_l] = 1'b1;
                3'b111: begin clr_m[ocw2_l] = 1'b1; new_low = int'(ocw2_l); end
                3'b110: new_low = int'(ocw2_l);
                3'b100: m_rot = 1'b1;
                3'b000: m_rot = 1'b0;
                default: ;
            endcase
        end
        m_isr = (m_isr & ~clr_m) | set_m;
        if (ltim) m_irr = ir_in;
        else      m_irr = (m_irr & ~irr_clr) | (ir_in & ~m_prev_ir);
        m_prev_ir = ir_in;
        m_prev_inta = inta_n;
        m_low = new_low;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("int_model", {7'd0, int_o}, {7'd0, m_int});
        check("irnum_model", {5'd0, ir_num}, 8'(m_irnum));
        check("cnt_model", {6'd0, inta_count}, 8'(m_cnt));
        check("irr_model", irr, m_irr);
        check("isr_model", isr, m_isr);
    endtask

    // inputs are set between the negedge and the following posedge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ir_in = 8'h00; inta_n = 1'b1; ocw2_wr = 1'b0; imr = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic ack_pulses();
        inta_n = 1'b0; cycle();
        inta_n = 1'b1; cycle();
        inta_n = 1'b0; cycle();
        inta_n = 1'b1; cycle();
    endtask

    task automatic ocw(input logic [2:0] cmd, input logic [2:0] l);
        ocw2_wr = 1'b1; ocw2_cmd = cmd; ocw2_l = l;
        cycle();
        ocw2_wr = 1'b0;
    endtask

    typedef struct {
        logic [7:0] ir;
        logic       inta;
        logic       e_int;
        logic [2:0] e_num;
        logic [1:0] e_cnt;
        logic [7:0] e_irr;
        logic [7:0] e_isr;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{8'h00, 1'b1, 1'b0, 3'd0, 2'd0, 8'h00, 8'h00};
        vt[1] = '{8'h04, 1'b1, 1'b0, 3'd0, 2'd0, 8'h04, 8'h00};
        vt[2] = '{8'h04, 1'b1, 1'b1, 3'd0, 2'd0, 8'h04, 8'h00};
        vt[3] = '{8'h04, 1'b0, 1'b1, 3'd2, 2'd1, 8'h00, 8'h04};
        vt[4] = '{8'h04, 1'b1, 1'b1, 3'd2, 2'd1, 8'h00, 8'h04};
        vt[5] = '{8'h04, 1'b0, 1'b1, 3'd2, 2'd2, 8'h00, 8'h04};
        vt[6] = '{8'h04, 1'b1, 1'b0, 3'd2, 2'd0, 8'h00, 8'h04};
        vt[7] = '{8'h00, 1'b1, 1'b0, 3'd2, 2'd0, 8'h00, 8'h04};

        do_reset();
        check("rst_int", {7'd0, int_o}, 8'h00);
        check("rst_irnum", {5'd0, ir_num}, 8'h00);
        check("rst_cnt", {6'd0, inta_count}, 8'h00);
        check("rst_irr", irr, 8'h00);
        check("rst_isr", isr, 8'h00);

        // edge-mode IR2 acknowledge, one row per clock
        for (int i = 0; i < 8; i++) begin
            ir_in = vt[i].ir; inta_n = vt[i].inta;
            cycle();
            check("tbl_int", {7'd0, int_o}, {7'd0, vt[i].e_int});
            check("tbl_irnum", {5'd0, ir_num}, {5'd0, vt[i].e_num});
            check("tbl_cnt", {6'd0, inta_count}, {6'd0, vt[i].e_cnt});
            check("tbl_irr", irr, vt[i].e_irr);
            check("tbl_isr", isr, vt[i].e_isr);
        end

        // nested: IR5 blocked by IR2 in service, IR1 preempts
        ir_in = 8'h20; cycle(); cycle(); cycle();
        check("nest_ir5_blocked", {7'd0, int_o}, 8'h00);
        ir_in = 8'h22; cycle(); cycle();
        check("nest_ir1_int", {7'd0, int_o}, 8'h01);
        ack_pulses();
        check("nest_isr", isr, 8'h06);
        check("nest_irnum", {5'd0, ir_num}, 8'h01);

        // AEOI with rotation
        do_reset();
        aeoi = 1'b1;
        ocw(3'b100, 3'd0);
        ir_in = 8'h08; cycle(); cycle();
        ack_pulses();
        check("aeoi_isr", isr, 8'h00);
        check("aeoi_irnum", {5'd0, ir_num}, 8'h03);
        check("aeoi_int", {7'd0, int_o}, 8'h00);
        ir_in = 8'h00; cycle();
        ir_in = 8'h14; cycle(); cycle();
        ack_pulses();
        check("aeoi_rot_ir4", {5'd0, ir_num}, 8'h04);

        // rotate on non-specific EOI, then set priority
        do_reset();
        aeoi = 1'b0;
        ir_in = 8'h10; cycle(); cycle();
        ack_pulses();
        ir_in = 8'h18; cycle(); cycle();
        ack_pulses();
        check("rot_isr_before", isr, 8'h18);
        ocw(3'b101, 3'd0);
        check("rot_ns_eoi_isr", isr, 8'h10);
        ocw(3'b110, 3'd5);
        ocw(3'b011, 3'd4);
        check("sp_eoi_isr", isr, 8'h00);
        ir_in = 8'h00; cycle();
        ir_in = 8'h60; cycle(); cycle();
        ack_pulses();
        check("setprio_ir6", {5'd0, ir_num}, 8'h06);
        ocw(3'b001, 3'd0);
        ocw(3'b001, 3'd0);
        check("ns_eoi_empty", isr, 8'h00);

        // level mode: request withdrawn before the first INTA_ fall
        do_reset();
        ltim = 1'b1;
        ir_in = 8'h40; cycle(); cycle();
        check("lvl_int", {7'd0, int_o}, 8'h01);
        ir_in = 8'h00; cycle();
        inta_n = 1'b0; cycle();
        check("spur_irnum", {5'd0, ir_num}, 8'h07);
        check("spur_isr", isr, 8'h00);
        check("spur_cnt", {6'd0, inta_count}, 8'h01);
        inta_n = 1'b1; cycle();
        inta_n = 1'b0; cycle();
        inta_n = 1'b1; cycle();
        check("spur_end_int", {7'd0, int_o}, 8'h00);
        check("spur_end_isr", isr, 8'h00);

        // asynchronous reset while in ACK1
        do_reset();
        ltim = 1'b0;
        ir_in = 8'h03; cycle(); cycle();
        inta_n = 1'b0; cycle();
        check("ack1_irr", irr, 8'h02);
        check("ack1_isr", isr, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("arst_int", {7'd0, int_o}, 8'h00);
        check("arst_isr", isr, 8'h00);
        check("arst_irr", irr, 8'h00);
        check("arst_cnt", {6'd0, inta_count}, 8'h00);
        do_reset();

        // randomized traffic in both trigger modes
        for (int seg = 0; seg < 2; seg++) begin
            do_reset();
            ltim = (seg == 1);
            aeoi = 1'($urandom_range(0, 1));
            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(0, 5) == 0) ir_in = ir_in ^ (8'h01 << $urandom_range(0, 7));
                if ($urandom_range(0, 40) == 0) imr = 8'($urandom) & 8'($urandom);
                if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
                ocw2_wr = ($urandom_range(0, 15) == 0);
                ocw2_cmd = 3'($urandom_range(0, 7));
                ocw2_l = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 200) == 0) aeoi = ~aeoi;
                cycle();
            end
            ocw2_wr = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
